// File: rtl/inst_issue_ctrl.sv
// Instruction-supply side of the SP core handshake: holds an instruction
// image, issues one word per transaction and flags core protocol faults.
module inst_issue_ctrl #(
   parameter int IMEM_DEPTH = 512,
   parameter int ADDR_W     = 9,
   parameter int MAX_LAT    = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [31:0]       prog_wdata,
   input  logic              start,
   input  logic [15:0]       run_len,
   input  logic              out_valid,
   input  logic [31:0]       inst_addr,
   output logic              in_valid,
   output logic [31:0]       inst,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err_code,
   output logic [15:0]       inst_count
);

   localparam int LAT_W = $clog2(MAX_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_e;

   localparam logic [1:0] E_NONE = 2'd0;
   localparam logic [1:0] E_TMO  = 2'd1;
   localparam logic [1:0] E_PROT = 2'd2;
   localparam logic [1:0] E_ADDR = 2'd3;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic              in_valid_q, in_valid_d;
   logic [31:0]       inst_q, inst_d;
   logic              done_q, done_d;
   logic [1:0]        err_q, err_d;

   logic [31:0]       imem_q [IMEM_DEPTH];
   logic              mem_we;
   logic [15:0]       cnt_inc;
   logic              addr_bad;
   logic [ADDR_W-1:0] word_idx;

   assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign mem_we   = prog_we && !busy;
   assign cnt_inc  = cnt_q + 16'd1;
   assign word_idx = inst_addr[ADDR_W+1:2];
   assign addr_bad = (inst_addr[1:0] != 2'b00) ||
                     (inst_addr[31:2] >= 30'(IMEM_DEPTH));

   always_ff @(posedge clk) begin
      if (mem_we) begin
         imem_q[prog_addr] <= prog_wdata;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      lat_d      = lat_q;
      in_valid_d = 1'b0;
      inst_d     = 32'd0;
      done_d     = done_q;
      err_d      = err_q;

      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               len_d  = run_len;
               pc_d   = '0;
               cnt_d  = 16'd0;
               done_d = 1'b0;
               err_d  = E_NONE;
               if (run_len == 16'd0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d    = S_ISSUE;
                  in_valid_d = 1'b1;
                  // Same-cycle image write to word 0 must be visible.
                  if (mem_we && (prog_addr == '0)) begin
                     inst_d = prog_wdata;
                  end else begin
                     inst_d = imem_q[0];
                  end
               end
            end
         end

         S_ISSUE: begin
            if (out_valid) begin
               state_d = S_ERR;
               err_d   = E_PROT;
            end else begin
               state_d = S_WAIT;
               lat_d   = '0;
            end
         end

         S_WAIT: begin
            if (out_valid) begin
               if (addr_bad) begin
                  state_d = S_ERR;
                  err_d   = E_ADDR;
               end else begin
                  pc_d  = word_idx;
                  cnt_d = cnt_inc;
                  if (cnt_inc == len_q) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d    = S_ISSUE;
                     in_valid_d = 1'b1;
                     inst_d     = imem_q[word_idx];
                  end
               end
            end else if (lat_q == LAT_W'(MAX_LAT - 1)) begin
               state_d = S_ERR;
               err_d   = E_TMO;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         len_q      <= 16'd0;
         cnt_q      <= 16'd0;
         lat_q      <= '0;
         in_valid_q <= 1'b0;
         inst_q     <= 32'd0;
         done_q     <= 1'b0;
         err_q      <= E_NONE;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         lat_q      <= lat_d;
         in_valid_q <= in_valid_d;
         inst_q     <= inst_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign in_valid   = in_valid_q;
   assign inst       = inst_q;
   assign done       = done_q;
   assign err_code   = err_q;
   assign inst_count = cnt_q;

endmodule

// File: tb/tb_inst_issue_ctrl.sv
// Bench for inst_issue_ctrl: acts as the SP core, predicts issued words
// and final status from the image contents and the planned core responses.
module tb_inst_issue_ctrl;

   localparam int DEPTH = 512;
   localparam int MAXL  = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        prog_we = 1'b0;
   logic [8:0]  prog_addr = '0;
   logic [31:0] prog_wdata = '0;
   logic        start = 1'b0;
   logic [15:0] run_len = '0;
   logic        out_valid = 1'b0;
   logic [31:0] inst_addr = '0;
   logic        in_valid;
   logic [31:0] inst;
   logic        busy;
   logic        done;
   logic [1:0]  err_code;
   logic [15:0] inst_count;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] img [DEPTH];
   int          lat_a [8];
   logic [31:0] addr_a [8];
   bit          hold_a [8];
   bit          wr_busy;

   inst_issue_ctrl #(
      .IMEM_DEPTH(DEPTH),
      .ADDR_W(9),
      .MAX_LAT(MAXL)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .prog_we(prog_we),
      .prog_addr(prog_addr),
      .prog_wdata(prog_wdata),
      .start(start),
      .run_len(run_len),
      .out_valid(out_valid),
      .inst_addr(inst_addr),
      .in_valid(in_valid),
      .inst(inst),
      .busy(busy),
      .done(done),
      .err_code(err_code),
      .inst_count(inst_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_plan();
      for (int i = 0; i < 8; i++) begin
         lat_a[i]  = 0;
         addr_a[i] = 32'd0;
         hold_a[i] = 1'b0;
      end
      wr_busy = 1'b0;
   endtask

   // Core side of one run; expectations come from img and the plan arrays.
   task automatic run_plan(input int len, input bit sw,
                           input logic [31:0] swd);
      int          cnt;
      int          pc;
      int          eerr;
      bit          edone;
      bit          fin;
      int          k;
      int          nw;
      logic [31:0] a;
      cnt = 0; pc = 0; eerr = 0; edone = 0; fin = 0; k = 0;
      run_len = 16'(len);
      start = 1'b1;
      if (sw) begin
         prog_we    = 1'b1;
         prog_addr  = 9'd0;
         prog_wdata = swd;
         img[0]     = swd;
      end
      tick();
      start   = 1'b0;
      prog_we = 1'b0;
      if (len == 0) begin
         edone = 1'b1;
         fin   = 1'b1;
         chk("zero_iv", 32'(in_valid), 32'd0);
         chk("zero_done", 32'(done), 32'd1);
      end
      while (!fin) begin
         chk("iv_hi", 32'(in_valid), 32'd1);
         chk("inst", inst, img[pc]);
         tick();
         chk("iv_lo", 32'(in_valid), 32'd0);
         nw = (lat_a[k] >= MAXL) ? MAXL - 1 : lat_a[k];
         for (int i = 0; i < nw; i++) begin
            if (i == 0 && wr_busy) begin
               prog_we    = 1'b1;
               prog_addr  = 9'(pc + 1);
               prog_wdata = ~img[(pc + 1) % DEPTH];
            end
            tick();
            prog_we = 1'b0;
         end
         if (lat_a[k] >= MAXL) begin
            chk("tmo_pre_busy", 32'(busy), 32'd1);
            tick();
            eerr = 1;
            fin  = 1'b1;
         end else begin
            a = addr_a[k];
            out_valid = 1'b1;
            inst_addr = a;
            tick();
            if (a[1:0] != 2'b00 || a[31:2] >= DEPTH) begin
               eerr = 3;
               fin  = 1'b1;
               out_valid = 1'b0;
            end else begin
               cnt++;
               pc = int'(a[31:2]);
               if (cnt == len) begin
                  edone = 1'b1;
                  fin   = 1'b1;
                  if (hold_a[k]) tick();
                  out_valid = 1'b0;
               end else if (hold_a[k]) begin
                  chk("iv_hold", 32'(in_valid), 32'd1);
                  chk("inst_hold", inst, img[pc]);
                  tick();
                  out_valid = 1'b0;
                  eerr = 2;
                  fin  = 1'b1;
               end else begin
                  out_valid = 1'b0;
               end
            end
         end
         k++;
      end
      tick();
      tick();
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_iv", 32'(in_valid), 32'd0);
      chk("end_inst", inst, 32'd0);
      chk("end_done", 32'(done), 32'(edone));
      chk("end_err", 32'(err_code), 32'(eerr));
      chk("end_cnt", 32'(inst_count), 32'(cnt));
   endtask

   initial begin
      clr_plan();
      #12;
      chk("rst_out", {15'd0, in_valid, busy, done, err_code, inst_count},
          32'd0);
      chk("rst_inst", inst, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      for (int i = 0; i < DEPTH; i++) begin
         img[i]     = $urandom;
         prog_we    = 1'b1;
         prog_addr  = 9'(i);
         prog_wdata = img[i];
         tick();
      end
      prog_we = 1'b0;

      clr_plan();
      for (int i = 0; i < 3; i++) begin
         lat_a[i]  = 2;
         addr_a[i] = 32'(4 * (i + 1));
      end
      run_plan(3, 1'b0, 32'd0);

      clr_plan();
      addr_a[0] = 32'h20;
      addr_a[1] = 32'h24;
      run_plan(2, 1'b0, 32'd0);

      clr_plan();
      lat_a[0] = MAXL;
      run_plan(2, 1'b0, 32'd0);

      clr_plan();
      lat_a[0] = MAXL - 1;
      addr_a[0] = 32'h7FC;
      run_plan(1, 1'b0, 32'd0);

      clr_plan();
      addr_a[0] = 32'h4;
      hold_a[0] = 1'b1;
      run_plan(3, 1'b0, 32'd0);

      clr_plan();
      addr_a[0] = 32'h6;
      run_plan(2, 1'b0, 32'd0);

      clr_plan();
      addr_a[0] = 32'h800;
      run_plan(2, 1'b0, 32'd0);

      clr_plan();
      addr_a[0] = 32'h4;
      run_plan(1, 1'b1, 32'hCAFE_F00D);

      clr_plan();
      wr_busy  = 1'b1;
      lat_a[0] = 2;
      addr_a[0] = 32'h4;
      addr_a[1] = 32'h8;
      run_plan(2, 1'b0, 32'd0);

      clr_plan();
      run_len = 16'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_out", {15'd0, in_valid, busy, done, err_code, inst_count},
          32'd0);
      chk("midrst_inst", inst, 32'd0);
      #3;
      rst_n = 1'b1;
      tick();
      run_plan(0, 1'b0, 32'd0);

      for (int r = 0; r < 40; r++) begin
         clr_plan();
         for (int i = 0; i < 8; i++) begin
            int sel;
            lat_a[i] = ($urandom_range(0, 15) < 2) ?
                       int'($urandom_range(10, 12)) :
                       int'($urandom_range(0, 9));
            sel = int'($urandom_range(0, 19));
            if (sel == 0)
               addr_a[i] = 32'($urandom_range(0, 2047)) | 32'd1;
            else if (sel == 1)
               addr_a[i] = 32'h800 + 32'(4 * $urandom_range(0, 100));
            else
               addr_a[i] = 32'($urandom_range(0, 511)) << 2;
            hold_a[i] = ($urandom_range(0, 9) == 0);
         end
         run_plan(int'($urandom_range(1, 6)), 1'b0, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
